// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants for the PS/2 keyboard receiver and key encoder.
//   - Prefix byte values (extended, break, pause).
//   - Bytes that carry no key information when no prefix is pending.
//   - Bit positions inside the 11-bit ps2_key event word.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int unsigned NUM_IGNORE = 6;
  // BAT-ok, ack, resend, echo, and the two error/overrun codes.
  localparam logic [7:0] IGNORE_CODES [NUM_IGNORE] = '{
    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF
  };

  localparam int unsigned KEY_TOGGLE  = 10;
  localparam int unsigned KEY_PRESSED = 9;
  localparam int unsigned KEY_EXT     = 8;

  function automatic logic is_ignore_code(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_IGNORE; i++) begin
      if (code == IGNORE_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_rx_serial.sv
// ps2_rx_serial: PS/2 line receiver.
//   clk_sys    : system clock, rising edge.
//   reset_n    : asynchronous active-low reset.
//   ps2_clk_in : raw PS/2 clock (asynchronous).
//   ps2_dat_in : raw PS/2 data (asynchronous).
//   byte_stb   : one-cycle strobe, byte_data holds a correctly framed byte.
//   byte_data  : last received data byte.
//   frame_err  : one-cycle pulse on bad start, parity or stop bit.
//   prefix_clr : one-cycle pulse telling the byte layer to drop pending prefixes
//                (parity/stop error or partial-frame timeout).
module ps2_rx_serial #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 48000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       prefix_clr
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           stb_q, stb_d;
  logic           err_q, err_d;
  logic           clr_q, clr_d;
  logic           fall;
  logic           dat;

  assign dat = dat_sync_q[1];

  // Glitch filter: the filtered level follows the synchronized clock only after
  // FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  // Frame deserializer; par_q accumulates XOR of data and parity, so a good
  // frame leaves it at 1 (odd parity).
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    clr_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: begin
          if (dat) begin
            err_d = 1'b1;
          end else begin
            bit_cnt_d = 4'd1;
            par_d     = 1'b0;
          end
        end
        4'd9: begin
          par_d     = par_q ^ dat;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (dat && par_q) begin
            stb_d = 1'b1;
          end else begin
            err_d = 1'b1;
            clr_d = 1'b1;
          end
        end
        default: begin
          shift_d   = {dat, shift_q[7:1]};
          par_d     = par_q ^ dat;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      // Only a partial frame can time out; an edge in the same cycle wins above.
      if (to_cnt_q == TCW'(TIMEOUT - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
        clr_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      clr_q      <= clr_d;
    end
  end

  assign byte_stb   = stb_q;
  assign byte_data  = shift_q;
  assign frame_err  = err_q;
  assign prefix_clr = clr_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: turns a raw PS/2 keyboard stream into toggle-flagged events.
//   clk_sys    : system clock, rising edge.
//   reset_n    : asynchronous active-low reset.
//   ps2_clk_in : raw PS/2 clock (asynchronous).
//   ps2_dat_in : raw PS/2 data (asynchronous).
//   ps2_key    : [10] toggles per event, [9] pressed, [8] extended, [7:0] code.
//   frame_err  : one-cycle pulse on a malformed frame.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 48000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic        byte_stb;
  logic [7:0]  byte_data;
  logic        prefix_clr;

  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [2:0]  skip_q, skip_d;
  logic [10:0] key_q, key_d;

  ps2_rx_serial #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .byte_stb   (byte_stb),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .prefix_clr (prefix_clr)
  );

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    key_d  = key_q;
    if (prefix_clr) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_stb) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (byte_data == PS2_PAUSE) begin
        // Pause is E1 followed by seven more bytes that carry no key event.
        skip_d = 3'd7;
      end else if (byte_data == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (!ext_q && !brk_q && is_ignore_code(byte_data)) begin
        // Keyboard housekeeping reply, not a key.
      end else begin
        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
        key_d[KEY_PRESSED] = ~brk_q;
        key_d[KEY_EXT]     = ext_q;
        key_d[7:0]         = byte_data;
        ext_d              = 1'b0;
        brk_d              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= 3'd0;
      key_q  <= 11'h000;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      skip_q <= skip_d;
      key_q  <= key_d;
    end
  end

  assign ps2_key = key_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: scoreboard bench for ps2_key_encoder.
module tb_ps2_key_encoder;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 1000;
  localparam int unsigned HALF = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder #(
    .FILTER_LEN (FL),
    .TIMEOUT    (TO)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [10:0] exp_q[$];
  int          exp_err = 0;
  int          seen_err = 0;
  bit          in_reset = 1'b1;
  logic [10:0] prev_key = 11'h000;
  logic        prev_err = 1'b0;

  // Reference model state: pending prefixes, bytes left to drop, toggle bit.
  bit m_ext, m_brk, m_tog;
  int m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit is_ign(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_tog = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!m_ext && !m_brk && is_ign(b)) begin
    end else begin
      m_tog = ~m_tog;
      exp_q.push_back({m_tog, ~m_brk, m_ext, b});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Device-side frame driver: data changes while clock is high.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits,
                            input int glitch_bit);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat_in = f[i];
      if (i == glitch_bit) begin
        repeat (5) @(negedge clk_sys);
        ps2_clk_in = 1'b0;
        repeat (FL - 4) @(negedge clk_sys);
        ps2_clk_in = 1'b1;
        repeat (HALF - 1 - FL) @(negedge clk_sys);
      end else begin
        repeat (HALF) @(negedge clk_sys);
      end
      ps2_clk_in = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
    end
    ps2_dat_in = 1'b1;
    repeat (2 * HALF) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] d);
    model_byte(d);
    send_frame(d, 1'b0, 11, -1);
  endtask

  task automatic send_bad(input logic [7:0] d);
    exp_err++;
    m_ext = 0;
    m_brk = 0;
    send_frame(d, 1'b1, 11, -1);
  endtask

  // Monitor: every change of ps2_key is an event and must match the queue head.
  always @(negedge clk_sys) begin
    if (in_reset) begin
      prev_key <= ps2_key;
      prev_err <= 1'b0;
    end else begin
      if (ps2_key !== prev_key) begin
        if (exp_q.size() == 0) check("unexpected_event", 32'(ps2_key), 32'(prev_key));
        else check("key_event", 32'(ps2_key), 32'(exp_q.pop_front()));
      end
      if (frame_err === 1'b1) begin
        seen_err <= seen_err + 1;
        check("err_pulse_width", 32'(prev_err), 32'd0);
      end
      prev_key <= ps2_key;
      prev_err <= frame_err;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r;
    model_reset();
    repeat (3) @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    in_reset = 1'b0;

    // Space make/break, then extended up-arrow make/break.
    send_byte(8'h29); send_byte(8'hF0); send_byte(8'h29);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

    // Bad parity, then a good frame of the same byte.
    send_bad(8'h1C);
    check("err_count_bad_parity", 32'(seen_err), 32'(exp_err));
    send_byte(8'h1C);

    // Partial frame abandoned past the timeout, then a clean frame.
    send_frame(8'h16, 1'b0, 5, -1);
    repeat (TO + 10) @(negedge clk_sys);
    check("err_count_timeout", 32'(seen_err), 32'(exp_err));
    send_byte(8'h16);

    // Pause sequence produces nothing; the following key does.
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h2E);

    // Short clock glitch inside a frame must not add a bit.
    model_byte(8'h36);
    send_frame(8'h36, 1'b0, 11, 4);
    check("err_count_glitch", 32'(seen_err), 32'(exp_err));
    check("queue_drained_pre_reset", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame.
    send_frame(8'h55, 1'b0, 5, -1);
    in_reset = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("midreset_key", 32'(ps2_key), 32'h000);
    check("midreset_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_sys);
    in_reset = 1'b0;
    send_byte(8'h1C);

    // Random byte stream biased toward prefixes, with occasional bad parity.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      if ($urandom_range(0, 7) == 0) send_bad(b);
      else send_byte(b);
    end

    repeat (50) @(negedge clk_sys);
    check("queue_drained_end", 32'(exp_q.size()), 32'd0);
    check("err_count_end", 32'(seen_err), 32'(exp_err));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
